// File: rtl/boss_hit_receiver.sv
// Boss hit receiver: bullet/hitbox overlap, HP tracking, hurt/dying/dead life cycle, health-bar pixel.
// Optional build macro BOSS_REGEN_EN adds slow HP regeneration while ALIVE.
module boss_hit_receiver #(
  parameter int BOSS_W       = 64,
  parameter int BOSS_H       = 64,
  parameter int MAX_HP       = 20,
  parameter int DAMAGE       = 1,
  parameter int IFRAMES      = 30,
  parameter int DEATH_FRAMES = 60,
  parameter int BAR_X        = 20,
  parameter int BAR_Y        = 10,
  parameter int BAR_SCALE    = 4,
  parameter int REGEN_FRAMES = 120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] BossX,
  input  logic [9:0] BossY,
  input  logic [9:0] Bullet_X,
  input  logic [9:0] Bullet_Y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       hit,
  output logic [7:0] boss_hp,
  output logic       boss_flash,
  output logic       boss_dying,
  output logic       boss_dead,
  output logic       isHealthBar
);

  typedef enum logic [1:0] {ALIVE, HURT, DYING, DEAD} state_t;

  localparam logic [7:0]  HP_MAX = 8'(MAX_HP);
  localparam logic [7:0]  DMG    = 8'(DAMAGE);
  localparam logic [7:0]  IF_1   = 8'(IFRAMES - 1);
  localparam logic [7:0]  DF_1   = 8'(DEATH_FRAMES - 1);
  localparam logic [10:0] BW_1   = 11'(BOSS_W - 1);
  localparam logic [10:0] BH_1   = 11'(BOSS_H - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, hp_n, hp_dec;
  logic       overlap;

  // Widened to 11 bits so a boss near the right/bottom edge does not wrap.
  logic [10:0] bul_x, bul_y, box_x, box_y;
  assign bul_x = {1'b0, Bullet_X};
  assign bul_y = {1'b0, Bullet_Y};
  assign box_x = {1'b0, BossX};
  assign box_y = {1'b0, BossY};

  assign overlap = (bul_x + 11'd1 >= box_x) && (bul_x <= box_x + BW_1) &&
                   (bul_y + 11'd1 >= box_y) && (bul_y <= box_y + BH_1) &&
                   (Bullet_Y < 10'd480);

  assign hit    = overlap && ((state == ALIVE) || (state == HURT));
  assign hp_dec = (boss_hp > DMG) ? (boss_hp - DMG) : 8'd0;

`ifdef BOSS_REGEN_EN
  localparam int RW = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
  localparam logic [RW-1:0] RF_1 = RW'(REGEN_FRAMES - 1);
  logic [RW-1:0] regen_cnt, regen_n;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hp_n    = boss_hp;
`ifdef BOSS_REGEN_EN
    regen_n = '0;
`endif
    case (state)
      ALIVE: begin
        if (hit) begin
          hp_n = hp_dec;
          if (hp_dec == 8'd0) begin
            state_n = DYING;
            cnt_n   = DF_1;
          end else begin
            state_n = HURT;
            cnt_n   = IF_1;
          end
        end
`ifdef BOSS_REGEN_EN
        else if (boss_hp < HP_MAX) begin
          if (regen_cnt == RF_1) hp_n = boss_hp + 8'd1;
          else                   regen_n = regen_cnt + 1'b1;
        end
`endif
      end
      HURT: begin
        if (cnt == 8'd0) state_n = ALIVE;
        else             cnt_n   = cnt - 8'd1;
      end
      DYING: begin
        if (cnt == 8'd0) state_n = DEAD;
        else             cnt_n   = cnt - 8'd1;
      end
      DEAD:    state_n = DEAD;
      default: state_n = ALIVE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= ALIVE;
      cnt        <= 8'd0;
      boss_hp    <= HP_MAX;
      boss_flash <= 1'b0;
      boss_dying <= 1'b0;
      boss_dead  <= 1'b0;
`ifdef BOSS_REGEN_EN
      regen_cnt  <= '0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      boss_hp    <= hp_n;
      boss_flash <= (state_n == HURT) && cnt_n[2];
      boss_dying <= (state_n == DYING);
      boss_dead  <= (state_n == DEAD);
`ifdef BOSS_REGEN_EN
      regen_cnt  <= regen_n;
`endif
    end
  end

  // Exclusive upper bound keeps the bar empty at hp = 0.
  logic [11:0] bar_end, draw_x;
  assign bar_end     = 12'(BAR_X) + 12'(boss_hp) * 12'(BAR_SCALE);
  assign draw_x      = {2'b00, DrawX};
  assign isHealthBar = (DrawY >= 10'(BAR_Y)) && (DrawY <= 10'(BAR_Y + 7)) &&
                       (draw_x >= 12'(BAR_X)) && (draw_x < bar_end);

endmodule

// File: doc/boss_hit_receiver.md
# boss_hit_receiver

Target-side counterpart to the player bullet: takes the bullet's per-frame position, asserts `hit` back to the bullet when it overlaps the boss hitbox, and tracks boss health. The block runs a life-cycle state machine with hurt invulnerability, a dying animation window and a dead state. It also drives a health-bar pixel flag for the colour mapper. It sits between the bullet and the boss sprite/colour logic, clocked once per frame.

## Interface
- `BOSS_W`, 64: hitbox width in pixels.
- `BOSS_H`, 64: hitbox height in pixels.
- `MAX_HP`, 20: starting and maximum health (≤ 63).
- `DAMAGE`, 1: HP removed per accepted hit.
- `IFRAMES`, 30: invulnerability frames after a hit (1–255).
- `DEATH_FRAMES`, 60: dying animation frames (1–255).
- `BAR_X`, 20 / `BAR_Y`, 10: health-bar top-left pixel.
- `BAR_SCALE`, 4: bar pixels per HP point; bar height is 8 px.
- `REGEN_FRAMES`, 120: frames per +1 HP (used only with `BOSS_REGEN_EN`).

- `frame_clk`  in  1  frame clock, one edge per video frame.
- `Reset`  in  1  reset, synchronous, active-high.
- `BossX`, `BossY`  in  10  boss hitbox top-left corner.
- `Bullet_X`, `Bullet_Y`  in  10  bullet top-left; the bullet is 2×2 px.
- `DrawX`, `DrawY`  in  10  current pixel being drawn.
- `hit`  out  1  combinational; the bullet has touched the boss.
- `boss_hp`  out  8  current HP.
- `boss_flash`  out  1  blink enable for the sprite while hurt.
- `boss_dying`  out  1  high in the DYING state.
- `boss_dead`  out  1  high in the DEAD state.
- `isHealthBar`  out  1  combinational; the current pixel is in the filled bar.

## Operation
- **Overlap rule.** Overlap holds when all of these are true, evaluated in 11-bit arithmetic so there is no wrap:
  - `Bullet_X+1 ≥ BossX` and `Bullet_X ≤ BossX+BOSS_W-1`
  - `Bullet_Y+1 ≥ BossY` and `Bullet_Y ≤ BossY+BOSS_H-1`
  - `Bullet_Y < 480`. This guard means the bullet's idle parking position (Y=500) never hits.
- **`hit` output.** `hit` = overlap AND state ∈ {ALIVE, HURT}. A bullet is absorbed during invulnerability but does no damage. In DYING and DEAD, `hit`=0 and bullets pass through.
- **ALIVE.** On overlap:
  - `hp_next` = `hp − DAMAGE`, saturating at 0.
  - If `hp_next` = 0, go to DYING with `cnt` = DEATH_FRAMES−1.
  - Otherwise go to HURT with `cnt` = IFRAMES−1.
- **HURT.** `cnt` decrements each frame. When `cnt` = 0, the next frame returns to ALIVE. Overlaps are ignored for damage.
- **DYING.** `cnt` decrements each frame. When `cnt` = 0, go to DEAD.
- **DEAD.** Terminal state; only `Reset` leaves it.
- **Flags.**
  - `boss_flash` = (state==HURT) & `cnt[2]`, giving a 4-frame on/off blink.
  - `boss_dying` = state==DYING; `boss_dead` = state==DEAD.
- **Health bar.** `isHealthBar` = `DrawY` ∈ [BAR_Y, BAR_Y+7] AND `DrawX` ∈ [BAR_X, BAR_X + hp·BAR_SCALE − 1]. When hp = 0 the bar is empty, not one pixel wide.

## Timing
- `Reset` has priority over every other input on a `frame_clk` edge.
- Reset values: state ALIVE, `hp` = MAX_HP, `cnt` = 0, `regen_cnt` = 0, `boss_flash`=0, `boss_dying`=0, `boss_dead`=0.
- `hit` is combinational from the current `Bullet_X`/`Bullet_Y` and the registered state, with zero latency. The bullet consumes it on the same edge.
- The HP decrement and state change take effect on the `frame_clk` edge where `hit`=1, so `boss_hp` updates 1 frame after overlap.
- HURT lasts exactly IFRAMES frames. DYING lasts exactly DEATH_FRAMES frames before DEAD.
- A hit held across consecutive frames costs only one DAMAGE, because the second frame is already in HURT.
- If `Reset` is asserted mid-HURT or mid-DYING, state returns to ALIVE with full HP on that edge. `hit` still reflects the pre-edge state in that cycle.
- A `hit` with hp ≤ DAMAGE goes straight to DYING and never enters HURT.

## Configuration
- `BOSS_REGEN_EN` defined:
  - In ALIVE with hp < MAX_HP, `regen_cnt` counts frames. At REGEN_FRAMES−1, `hp` increments by 1 and `regen_cnt` clears.
  - A hit in the same frame wins: no regen that frame, and `regen_cnt` clears.
  - `regen_cnt` is held at 0 outside ALIVE.
- `BOSS_REGEN_EN` undefined: `regen_cnt` is not generated and HP never increases except via `Reset`.

## Test plan
- Reset, then bullet at (0,500) with boss at (400,200) → `hit`=0, `boss_hp`=20, `isHealthBar`=1 at (99,10) and 0 at (100,10).
- Bullet at (399,263), touching the corner → `hit`=1; next frame `boss_hp`=19 and `boss_flash` pattern starts. Bullet at (398,200) → `hit`=0.
- Hold overlap for 35 frames → only 2 HP lost (one at frame 0, one after the 30-frame HURT window); `boss_flash` toggles every 4 frames.
- Set hp to 1 via 19 spaced hits, then hit once more → `boss_dying`=1 for 60 frames, then `boss_dead`=1. `hit`=0 while bullets overlap in both states; the bar is empty.
- Assert `Reset` at frame 10 of DYING → next frame ALIVE, `boss_hp`=20, `boss_dying`=0.
- With `BOSS_REGEN_EN`: hp=15 and no hits for 240 frames → hp=17. A hit on the regen frame → hp=14, `regen_cnt`=0.
